// File: rtl/brew_sequencer_pkg.sv
//------------------------------------------------------------------------------
// brew_sequencer_pkg
//   Shared definitions for the brew sequencer: state encodings, fault codes
//   and a sensor-priority helper used wherever cup/water are both checked.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package brew_sequencer_pkg;

  // 3-bit brew state encoding, also used by the coffee FSM side.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_GRIND = 3'd2,
    ST_HEAT  = 3'd3,
    ST_POUR  = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } brew_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_NO_CUP   = 2'd1;
  localparam logic [1:0] FAULT_NO_WATER = 2'd2;
  localparam logic [1:0] FAULT_HEAT_TO  = 2'd3;

  // A missing cup outranks low water when both are bad at once.
  function automatic logic [1:0] sensor_fault(input logic cup_present,
                                              input logic water_ok);
    if (!cup_present) begin
      return FAULT_NO_CUP;
    end else if (!water_ok) begin
      return FAULT_NO_WATER;
    end
    return FAULT_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/brew_timer.sv
//------------------------------------------------------------------------------
// brew_timer
//   Loadable down-counter used to time each brew stage.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     i_load         load i_load_val (wins over i_dec)
//     i_load_val     value to load
//     i_dec          decrement by one, saturating at zero
//     o_zero         counter currently equals zero
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module brew_timer #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/brew_sequencer.sv
//------------------------------------------------------------------------------
// brew_sequencer
//   Runs grind -> heat -> pour once the coffee FSM raises coffee_make, then
//   returns a one-cycle coffee_out pulse. Sensor faults are latched and hold
//   every actuator off until acknowledged with coffee_make released.
//   Ports:
//     clk, reset_n     clock, asynchronous active-low reset
//     coffee_make      brew request level (rising edge starts a brew)
//     cup_present      cup sensor
//     water_ok         water-level sensor
//     temp_ok          boiler-at-temperature sensor
//     fault_clr        fault acknowledge
//     grinder_on       grinder drive
//     heater_on        heater drive
//     pump_on          pump drive
//     coffee_out       one-cycle brew-complete pulse
//     busy             state is not IDLE
//     fault            state is FAULT
//     fault_code       0 none, 1 no cup, 2 no water, 3 heat timeout
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module brew_sequencer #(
  parameter int unsigned GRIND_CYC    = 4,
  parameter int unsigned PUMP_CYC     = 8,
  parameter int unsigned HEAT_TIMEOUT = 16,
  parameter int unsigned TIMER_W      = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       coffee_make,
  input  logic       cup_present,
  input  logic       water_ok,
  input  logic       temp_ok,
  input  logic       fault_clr,
  output logic       grinder_on,
  output logic       heater_on,
  output logic       pump_on,
  output logic       coffee_out,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code
);

  import brew_sequencer_pkg::*;

  // Stage timers count down to zero, so each loads its duration minus one.
  localparam logic [TIMER_W-1:0] c_grind_load = TIMER_W'(GRIND_CYC - 1);
  localparam logic [TIMER_W-1:0] c_heat_load  = TIMER_W'(HEAT_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] c_pump_load  = TIMER_W'(PUMP_CYC - 1);

  brew_state_t        r_state;
  brew_state_t        w_state_nxt;
  logic [1:0]         r_fault_code;
  logic [1:0]         w_fault_code_nxt;
  logic               r_coffee_make_d;
  logic               w_start;
  logic [1:0]         w_sensor_fault;
  logic               w_tmr_load;
  logic [TIMER_W-1:0] w_tmr_load_val;
  logic               w_tmr_dec;
  logic               w_tmr_zero;

  // Delay register resets high: a request already held across reset release
  // must not be mistaken for a fresh rising edge.
  assign w_start        = coffee_make & ~r_coffee_make_d;
  assign w_sensor_fault = sensor_fault(cup_present, water_ok);

  brew_timer #(
    .TIMER_W    (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_fault_code    <= FAULT_NONE;
      r_coffee_make_d <= 1'b1;
    end else begin
      r_state         <= w_state_nxt;
      r_fault_code    <= w_fault_code_nxt;
      r_coffee_make_d <= coffee_make;
    end
  end

  // In every active stage, a dropped request is checked first so an abort
  // always wins over faults, timeouts and stage completion.
  always_comb begin
    w_state_nxt      = r_state;
    w_fault_code_nxt = r_fault_code;
    w_tmr_load       = 1'b0;
    w_tmr_load_val   = '0;
    w_tmr_dec        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (!coffee_make) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sensor_fault != FAULT_NONE) begin
          w_state_nxt      = ST_FAULT;
          w_fault_code_nxt = w_sensor_fault;
        end else begin
          w_state_nxt    = ST_GRIND;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = c_grind_load;
        end
      end

      ST_GRIND: begin
        if (!coffee_make) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmr_zero) begin
          w_state_nxt    = ST_HEAT;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = c_heat_load;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_HEAT: begin
        // Reaching temperature on the last allowed cycle still counts.
        if (!coffee_make) begin
          w_state_nxt = ST_IDLE;
        end else if (temp_ok) begin
          w_state_nxt    = ST_POUR;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = c_pump_load;
        end else if (w_tmr_zero) begin
          w_state_nxt      = ST_FAULT;
          w_fault_code_nxt = FAULT_HEAT_TO;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_POUR: begin
        if (!coffee_make) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sensor_fault != FAULT_NONE) begin
          w_state_nxt      = ST_FAULT;
          w_fault_code_nxt = w_sensor_fault;
        end else if (w_tmr_zero) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      ST_FAULT: begin
        // Leaving needs the request withdrawn too, so an acknowledged fault
        // cannot immediately relaunch a brew on a stale request.
        if (fault_clr && !coffee_make) begin
          w_state_nxt      = ST_IDLE;
          w_fault_code_nxt = FAULT_NONE;
        end
      end

      default: begin
        w_state_nxt      = ST_IDLE;
        w_fault_code_nxt = FAULT_NONE;
      end
    endcase
  end

  // Outputs depend only on registered state, never directly on inputs.
  assign grinder_on = (r_state == ST_GRIND);
  assign heater_on  = (r_state == ST_HEAT) || (r_state == ST_POUR);
  assign pump_on    = (r_state == ST_POUR);
  assign coffee_out = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign fault      = (r_state == ST_FAULT);
  assign fault_code = r_fault_code;

endmodule

`default_nettype wire

// File: tb/tb_brew_sequencer.sv
//------------------------------------------------------------------------------
// tb_brew_sequencer
//   Self-checking bench for brew_sequencer: a per-cycle vector table for the
//   steady-state scenarios plus directed sequences for aborts, mid-pour
//   faults and asynchronous reset.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_brew_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       coffee_make, cup_present, water_ok, temp_ok, fault_clr;
  logic       grinder_on, heater_on, pump_on, coffee_out, busy, fault;
  logic [1:0] fault_code;
  logic [7:0] obs;

  int n_checks = 0;
  int n_pass   = 0;
  int co_cnt   = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  brew_sequencer #(
    .GRIND_CYC    (4),
    .PUMP_CYC     (8),
    .HEAT_TIMEOUT (16),
    .TIMER_W      (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .coffee_make (coffee_make),
    .cup_present (cup_present),
    .water_ok    (water_ok),
    .temp_ok     (temp_ok),
    .fault_clr   (fault_clr),
    .grinder_on  (grinder_on),
    .heater_on   (heater_on),
    .pump_on     (pump_on),
    .coffee_out  (coffee_out),
    .busy        (busy),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  // Observed outputs: {grinder, heater, pump, coffee_out, busy, fault, code}
  assign obs = {grinder_on, heater_on, pump_on, coffee_out, busy, fault, fault_code};

  localparam logic [7:0] E_IDLE  = 8'b0000_0000;
  localparam logic [7:0] E_CHECK = 8'b0000_1000;
  localparam logic [7:0] E_GRIND = 8'b1000_1000;
  localparam logic [7:0] E_HEAT  = 8'b0100_1000;
  localparam logic [7:0] E_POUR  = 8'b0110_1000;
  localparam logic [7:0] E_DONE  = 8'b0001_1000;
  localparam logic [7:0] E_F1    = 8'b0000_1101;
  localparam logic [7:0] E_F2    = 8'b0000_1110;
  localparam logic [7:0] E_F3    = 8'b0000_1111;

  // Mid-cycle monitor: counts brew-complete pulses and grinder/pump overlap.
  always @(negedge clk) begin
    if (reset_n) begin
      if (coffee_out) co_cnt++;
      if (grinder_on && pump_on) overlap++;
    end
  end

  // Inputs packed as {coffee_make, cup_present, water_ok, temp_ok, fault_clr}
  typedef struct {
    string      name;
    logic [4:0] in;
    logic [7:0] exp;
    int         reps;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic [4:0] in,
                              input logic [7:0] exp, input int reps);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    v.reps = reps;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %b expected %b (g h p co busy f code)", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic [4:0] in);
    {coffee_make, cup_present, water_ok, temp_ok, fault_clr} = in;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int co_before;
    int found;

    // 1: full brew, all sensors good
    add("t1_check", 5'b11110, E_CHECK, 1);
    add("t1_grind", 5'b11110, E_GRIND, 4);
    add("t1_heat",  5'b11110, E_HEAT,  1);
    add("t1_pour",  5'b11110, E_POUR,  8);
    add("t1_done",  5'b11110, E_DONE,  1);
    add("t1_idle",  5'b11110, E_IDLE,  1);
    add("t1_rel",   5'b01110, E_IDLE,  1);
    // 2: no cup -> fault 1; clear only with coffee_make low
    add("t2_check", 5'b10110, E_CHECK, 1);
    add("t2_fault", 5'b10110, E_F1,    2);
    add("t2_clr_cm_hi", 5'b10111, E_F1, 1);
    add("t2_cm_lo_noclr", 5'b00110, E_F1, 1);
    add("t2_clr",   5'b00111, E_IDLE,  1);
    add("t2_idle",  5'b01110, E_IDLE,  1);
    // 3: boiler never ready -> heat timeout after 16 cycles
    add("t3_check", 5'b11100, E_CHECK, 1);
    add("t3_grind", 5'b11100, E_GRIND, 4);
    add("t3_heat",  5'b11100, E_HEAT,  16);
    add("t3_fault", 5'b11100, E_F3,    2);
    add("t3_clr",   5'b01101, E_IDLE,  1);
    add("t3_idle",  5'b01110, E_IDLE,  1);

    reset_n = 1'b0;
    drive(5'b01110);
    repeat (2) step();
    check("reset_state", obs, E_IDLE);
    reset_n = 1'b1;
    step();
    check("post_reset_idle", obs, E_IDLE);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive(vecs[i].in);
        step();
        check(vecs[i].name, obs, vecs[i].exp);
      end
    end

    // 4: water drops in the third pour cycle
    drive(5'b11110);
    repeat (7) step();
    check("t4_pour1", obs, E_POUR);
    repeat (2) step();
    check("t4_pour3", obs, E_POUR);
    co_before = co_cnt;
    drive(5'b11010);
    step();
    check("t4_fault", obs, E_F2);
    repeat (3) step();
    check("t4_fault_held", obs, E_F2);
    check_int("t4_no_coffee", co_cnt, co_before);
    drive(5'b01111);
    step();
    check("t4_clr", obs, E_IDLE);
    drive(5'b01110);
    step();

    // 5: abort in grind, then restart and measure latency
    co_before = co_cnt;
    drive(5'b11110);
    repeat (3) step();
    check("t5_grind", obs, E_GRIND);
    drive(5'b01110);
    step();
    check("t5_abort", obs, E_IDLE);
    drive(5'b11110);
    step();
    check("t5_recheck", obs, E_CHECK);
    check_int("t5_no_coffee_abort", co_cnt, co_before);
    found = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (coffee_out && found < 0) found = k;
      if (found >= 0) break;
    end
    check_int("t5_latency", found, 14);
    step();
    check("t5_idle_after", obs, E_IDLE);
    drive(5'b01110);
    step();

    // 6: async reset during pour, request held across release
    drive(5'b11110);
    repeat (8) step();
    check("t6_pour", obs, E_POUR);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_reset", obs, E_IDLE);
    repeat (2) step();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
    check("t6_no_restart", obs, E_IDLE);
    drive(5'b01110);
    step();
    drive(5'b11110);
    step();
    check("t6_new_check", obs, E_CHECK);
    drive(5'b01110);
    step();
    check("t6_abort_check", obs, E_IDLE);

    check_int("coffee_pulses", co_cnt, 2);
    check_int("grind_pump_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
